mdu_32: RTL
===========

# mdu_32

Iterative 32-bit multiply/divide unit for the execute stage of the microcomputer CPU. It implements MULT, MULTU, DIV and DIVU into architectural HI/LO registers, and supports direct HI/LO writes (MTHI/MTLO). Its `hi`/`lo` outputs are one input of the 32-bit 2:1 result mux ahead of register writeback; the other input is the ALU result. The controller stalls the pipeline on `busy`.

## Interface
- `WIDTH`, 32: operand and HI/LO width. Only 32 is supported.
- `clk`  in  1  rising-edge clock; all state updates on this edge.
- `rst_n`  in  1  reset; one clock; reset is synchronous and active-low.
- `start`  in  1  launch operation; sampled only in IDLE.
- `op`  in  2  operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `a`  in  32  multiplicand / dividend (rs).
- `b`  in  32  multiplier / divisor (rt).
- `hi_we`  in  1  write `wdata` into HI (MTHI).
- `lo_we`  in  1  write `wdata` into LO (MTLO).
- `wdata`  in  32  HI/LO write data.
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse when HI/LO take a new result.
- `hi`  out  32  HI register: product[63:32] or remainder.
- `lo`  out  32  LO register: product[31:0] or quotient.

## Operation
- States: IDLE, RUN, FIN.
- IDLE, `start`=1: latch `op`, the operand magnitudes (two's-complement abs for signed ops), and the result signs. Clear the 6-bit iteration counter. Go to RUN.
- RUN: one radix-2 step per cycle.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract into a 33-bit partial remainder.
  - After 32 steps, go to FIN.
- FIN: apply sign correction, write HI/LO, pulse `done`, go to IDLE.
- Sign rules:
  - MULT: the 64-bit product is negated if sign(a) differs from sign(b).
  - DIV: the quotient is negated if signs differ; the remainder takes the sign of `a`.
- Divide by zero (`b`=0, either divide op): LO=0xFFFFFFFF and HI=`a` (unmodified). Latency is the normal latency. No exception is raised.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. This falls out of the unsigned-magnitude datapath and needs no special case.
- `start` while `busy`: ignored. No latch, and the in-flight operation is unaffected.
- `hi_we`/`lo_we` while `busy`: ignored and the write is dropped. The controller must not issue them.
- `hi_we`/`lo_we` in IDLE: the write takes effect at the edge.
- `hi_we`/`lo_we` together with `start` in IDLE: the write happens, the op launches, and its result later overwrites HI/LO.
- Reset (at the edge, any state, including mid-RUN):
  - state goes to IDLE and the operation is aborted;
  - `hi`=0, `lo`=0, `busy`=0, `done`=0;
  - accumulator and counter are cleared.

## Timing
- `start` is accepted at edge E0. `busy`=1 from E0 until E33.
- RUN steps occur at edges E1..E32.
- FIN writes HI/LO at E33. After E33: `done`=1 for exactly one cycle, `busy`=0, and the new `hi`/`lo` are visible.
- Latency: 33 cycles from the accepting edge to the result, identical for all four ops and for divide by zero.
- Back-to-back: a `start` in the cycle where `done`=1 is accepted. The result of that operation appears 33 cycles later.
- `busy`, `done`, `hi` and `lo` are registered outputs with no combinational path from inputs.
- Operands are captured at E0. `a` and `b` may change freely afterwards.

## Structure
- Shared package `mdu_pkg` holds:
  - op codes `OP_MULTU`/`OP_MULT`/`OP_DIVU`/`OP_DIV`;
  - state encoding `S_IDLE`/`S_RUN`/`S_FIN`;
  - `MDU_ITER`=32.
- The execute-stage decoder imports `mdu_pkg` for the op codes.
- One natural sub-module: `neg_abs_32`, a combinational conditional two's-complement negate. It is instantiated for the operand abs and for quotient/remainder sign fix. The 64-bit product negate is done inline.
- The rest is a single module: FSM, counter, 64-bit accumulator and 33-bit remainder datapath.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. `done` is high exactly 33 cycles after `start`, and `busy` is high for those 33 cycles.
- MULT −3 × 7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. DIV −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 100 / 0 → LO=0xFFFFFFFF, HI=0x00000064. DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- Issue MULTU 5×6, then pulse `start` with DIVU at cycle 10 and `hi_we` with `wdata`=0x1234 at cycle 12 → both are ignored, and the result is HI=0, LO=30.
- `hi_we`, `wdata`=0xDEADBEEF in IDLE → `hi`=0xDEADBEEF next cycle. Then `start` in the `done` cycle of a prior op → the second op is accepted and completes 33 cycles later.
- Deassert `rst_n` at cycle 15 of a DIV → next cycle `busy`=0, `done`=0, `hi`=`lo`=0. A fresh MULTU 2×3 then yields LO=6 after 33 cycles.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Op codes, FSM state encoding and iteration count.
package mdu_pkg;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    localparam int MDU_ITER = 32;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return op[0];
    endfunction

endpackage

// File: rtl/neg_abs_32.sv
// Conditional two's-complement negate, used for operand
// magnitudes and for quotient/remainder sign correction.
module neg_abs_32 (
    input  logic [31:0] x,
    input  logic        neg,
    output logic [31:0] y
);

    assign y = neg ? (~x + 32'd1) : x;

endmodule

// File: rtl/mdu_32.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers.
// Radix-2 shift-add multiply, restoring divide, 33-cycle latency.
module mdu_32
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [1:0]  state;
    logic [5:0]  cnt;
    logic        is_div;
    logic        neg_res;
    logic        neg_rem;
    logic [31:0] opnd;
    logic [63:0] acc;
    logic [31:0] rem;

    logic        sa;
    logic        sb;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] lo_div;
    logic [31:0] hi_div;
    logic [32:0] msum;
    logic [32:0] trial;
    logic [63:0] prod;

    assign sa = op_is_signed(op) & a[31];
    assign sb = op_is_signed(op) & b[31];

    neg_abs_32 u_abs_a (.x(a), .neg(sa), .y(mag_a));
    neg_abs_32 u_abs_b (.x(b), .neg(sb), .y(mag_b));
    neg_abs_32 u_fix_q (.x(acc[31:0]), .neg(neg_res), .y(lo_div));
    neg_abs_32 u_fix_r (.x(rem), .neg(neg_rem), .y(hi_div));

    // Multiply step: conditionally add multiplicand into upper half.
    assign msum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    // Divide step: trial subtract of divisor from shifted remainder.
    assign trial = {rem, acc[31]} - {1'b0, opnd};
    assign prod  = neg_res ? (~acc + 64'd1) : acc;

    // FSM, iteration counter, datapath and HI/LO registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= 6'd0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            opnd    <= 32'd0;
            acc     <= 64'd0;
            rem     <= 32'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start) begin
                        state  <= S_RUN;
                        busy   <= 1'b1;
                        cnt    <= 6'd0;
                        is_div <= op_is_div(op);
                        rem    <= 32'd0;
                        if (op_is_div(op)) begin
                            opnd    <= mag_b;
                            acc     <= {32'd0, mag_a};
                            // b == 0 leaves the all-ones quotient untouched
                            neg_res <= (sa ^ sb) & (b != '0);
                            neg_rem <= sa;
                        end else begin
                            opnd    <= mag_a;
                            acc     <= {32'd0, mag_b};
                            neg_res <= sa ^ sb;
                            neg_rem <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    if (is_div) begin
                        if (!trial[32]) rem <= trial[31:0];
                        else            rem <= {rem[30:0], acc[31]};
                        acc[31:0] <= {acc[30:0], ~trial[32]};
                    end else begin
                        acc <= {msum, acc[31:1]};
                    end
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'(MDU_ITER - 1)) state <= S_FIN;
                end
                S_FIN: begin
                    hi    <= is_div ? hi_div : prod[63:32];
                    lo    <= is_div ? lo_div : prod[31:0];
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
